alu_seq: RTL
============

# alu_seq

Parametrised, registered ALU for the MIPS datapath. It adds a Start/Busy/Done handshake so that iterative operations can share the unit with single-cycle logic ops:
- working shifts and rotates;
- signed multiply producing a 2·WIDTH product;
- unsigned divide producing quotient and remainder.

It sits in the EX stage. The hazard unit stalls the pipeline while Busy is high.

## Interface
- WIDTH, 32: operand and result width (≥ 8, power of 2).
- SHW, $clog2(WIDTH): shift-amount width (localparam, not overridable).
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  request an operation. Sampled only in IDLE.
- ALUControl  in  4  operation select, captured with Start.
- A, B  in  WIDTH each  operands, captured with Start.
- Busy  out  1  an iterative operation is in progress.
- Done  out  1  one-cycle pulse: ALUResult/HiResult updated this cycle.
- ALUResult  out  WIDTH  result, or low product / quotient.
- HiResult  out  WIDTH  high product / remainder; 0 for single-cycle ops.
- Zero  out  1  (ALUResult == 0), decoded from the registered result.

## Operation
- ALUControl codes, single-cycle ops:
  - 0 AND; 1 OR; 2 ADD (wraps mod 2^WIDTH); 3 XOR.
  - 4 SLL A by B[SHW-1:0]; 5 SRL (logical) by B[SHW-1:0].
  - 6 SUB (wraps).
  - 7 SLT: signed, result 1/0.
  - 8 ROTL and 9 ROTR, by B[SHW-1:0]. An amount of 0 returns A.
  - 12 NOR; 14 ERR: all ones.
  - 10, 11: result 0.
- ALUControl codes, iterative ops:
  - 15 MUL, signed. {HiResult, ALUResult} = A·B as a 2·WIDTH two's-complement value.
  - 13 DIVU, unsigned. ALUResult = A/B, HiResult = A%B.
- DIVU with B == 0 is single-cycle: ALUResult = all ones, HiResult = A.
- Upper shift-amount bits are ignored, e.g. a shift by 33 at WIDTH 32 acts as a shift by 1.
- MUL datapath:
  - radix-2 shift-add on the operand magnitudes, one bit per cycle;
  - the product is negated on the final write when the operand signs differ.
- DIVU datapath: restoring division, one quotient bit per cycle.
- FSM states: IDLE, RUN.
  - IDLE & Start & iterative op (excluding DIVU with B == 0) → RUN. Operands captured; iteration counter set to WIDTH−1.
  - IDLE & Start & single-cycle op → stay IDLE. Result registered at this edge; Done = 1 next cycle.
  - RUN, counter ≠ 0 → RUN, counter −1.
  - RUN, counter == 0 → IDLE. Final result written; Done = 1 next cycle.
- Start while in RUN is ignored: no queuing, no effect on the captured operands.
- Outputs hold their last value until the next completed operation.
- Reset, from any state including mid-RUN:
  - state → IDLE; counter, Busy, Done, ALUResult and HiResult → 0; Zero → 1;
  - the in-flight operation is discarded and no Done is produced.
- Reset has priority over Start in the same cycle.

## Timing
- T = the cycle in which Start is sampled high in IDLE.
- Single-cycle op: results valid and Done high in T+1. Busy never asserts.
- MUL / DIVU: Busy high in T+1 … T+WIDTH; results valid and Done high in T+WIDTH+1. This is 33 cycles at WIDTH 32.
- Back-to-back: the FSM is in IDLE during the Done cycle, so Start in that cycle is accepted. This gives a throughput of one op per WIDTH+1 cycles for iterative ops and one per cycle for single-cycle ops.
- Zero is valid in the same cycle as ALUResult (registered result, combinational compare).
- There is no combinational path from A, B or ALUControl to any output.

## Structure
- alu_pkg holds:
  - localparam opcodes: OP_AND … OP_MUL;
  - the FSM state enum {IDLE, RUN};
  - a function is_iterative(op, b).
- The opcode values are shared with the ALU control decoder.
- Sub-module alu_seq_muldiv holds the iterative engine: shared accumulator/shift register, counter and sign fix-up.
  - It takes load/op/operands and returns result_lo, result_hi and last.
- The top-level module holds the FSM, the single-cycle datapath and the output registers.

## Test plan
- Reset → ALUResult = 0, HiResult = 0, Zero = 1, Busy = 0, Done = 0. Start asserted together with Reset → ignored.
- ADD 7 + 5 → ALUResult = 12, Zero = 0, Done in T+1. SUB 5 − 5 → 0, Zero = 1. SLT 0xFFFFFFFF, 1 → 1. ADD 0xFFFFFFFF + 1 → 0 (wrap).
- ROTR 0x80000001 by 1 → 0xC0000000. ROTL 0x80000001 by 4 → 0x00000018. SLL 1 by 33 → 2. SRL 0x80000000 by 31 → 1.
- MUL 0xFFFFFFFD (−3) × 7 → ALUResult = 0xFFFFFFEB, HiResult = 0xFFFFFFFF.
  - Busy for exactly 32 cycles, Done only in T+33.
  - Start with ADD at T+5 → ignored.
  - New Start in the Done cycle → accepted.
- DIVU 100 / 7 → 14 remainder 2, Done in T+33. DIVU 9 / 0 → 0xFFFFFFFF remainder 9, Done in T+1, Busy never high.
- Reset asserted in cycle T+10 of a MUL → Busy = 0, outputs 0, no Done pulse. A following ADD completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes (common with the ALU control decoder),
// the sequencer state type and the iterative-op classifier.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_SLL  = 4'd4;
    localparam logic [3:0] OP_SRL  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_ROTL = 4'd8;
    localparam logic [3:0] OP_ROTR = 4'd9;
    localparam logic [3:0] OP_NOR  = 4'd12;
    localparam logic [3:0] OP_DIVU = 4'd13;
    localparam logic [3:0] OP_ERR  = 4'd14;
    localparam logic [3:0] OP_MUL  = 4'd15;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } alu_state_t;

    // Divide by zero resolves in one cycle, so only a non-zero divisor iterates.
    function automatic logic is_iterative(input logic [3:0] op, input logic b_zero);
        return (op == OP_MUL) || ((op == OP_DIVU) && !b_zero);
    endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative engine: radix-2 shift-add signed multiply and restoring unsigned
// divide sharing one accumulator/shift register pair.
//   clk, reset   : clock, synchronous active-high reset
//   load         : capture operands and op, counter := WIDTH-1
//   step         : advance one iteration
//   op_mul       : 1 = signed multiply, 0 = unsigned divide (at load)
//   a, b         : operands (at load)
//   result_lo/hi : final result as it stands after the current step
//   last         : counter has reached zero (current step is the final one)
module alu_seq_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             op_mul,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             last
);

    localparam int unsigned SHW = $clog2(WIDTH);

    logic [WIDTH:0]   acc;      // product high half / partial remainder
    logic [WIDTH-1:0] lo;       // multiplier shifting out / dividend->quotient
    logic [WIDTH-1:0] opnd;     // multiplicand magnitude or divisor
    logic             is_mul;
    logic             neg;      // operand signs differ: negate final product
    logic [SHW-1:0]   cnt;

    logic [WIDTH:0]     acc_n;
    logic [WIDTH-1:0]   lo_n;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    // Operand magnitudes; the most negative value maps to 2^(WIDTH-1), which fits.
    always_comb begin
        mag_a = a[WIDTH-1] ? WIDTH'(-a) : a;
        mag_b = b[WIDTH-1] ? WIDTH'(-b) : b;
    end

    // One iteration of whichever algorithm is loaded.
    always_comb begin
        sum   = acc + (lo[0] ? {1'b0, opnd} : '0);
        trial = {acc[WIDTH-1:0], lo[WIDTH-1]};
        diff  = trial - {1'b0, opnd};
        if (is_mul) begin
            acc_n = {1'b0, sum[WIDTH:1]};
            lo_n  = {sum[0], lo[WIDTH-1:1]};
        end else begin
            acc_n = (trial >= {1'b0, opnd}) ? diff : trial;
            lo_n  = {lo[WIDTH-2:0], (trial >= {1'b0, opnd})};
        end
    end

    // Result taps after the current step, with the multiply sign fix-up.
    always_comb begin
        prod = {acc_n[WIDTH-1:0], lo_n};
        if (neg) begin
            prod = (2*WIDTH)'(-prod);
        end
        if (is_mul) begin
            result_lo = prod[WIDTH-1:0];
            result_hi = prod[2*WIDTH-1:WIDTH];
        end else begin
            result_lo = lo_n;
            result_hi = acc_n[WIDTH-1:0];
        end
        last = (cnt == '0);
    end

    // Engine registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            lo     <= '0;
            opnd   <= '0;
            is_mul <= 1'b0;
            neg    <= 1'b0;
            cnt    <= '0;
        end else if (load) begin
            acc    <= '0;
            is_mul <= op_mul;
            cnt    <= SHW'(WIDTH - 1);
            if (op_mul) begin
                lo   <= mag_b;
                opnd <= mag_a;
                neg  <= a[WIDTH-1] ^ b[WIDTH-1];
            end else begin
                lo   <= a;
                opnd <= b;
                neg  <= 1'b0;
            end
        end else if (step) begin
            acc <= acc_n;
            lo  <= lo_n;
            if (cnt != '0) begin
                cnt <= cnt - SHW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered EX-stage ALU with Start/Busy/Done handshake. Single-cycle ops
// complete in one cycle; MUL and DIVU (non-zero divisor) take WIDTH+1.
//   Clk, Reset        : clock, synchronous active-high reset
//   Start             : request, sampled only in IDLE
//   ALUControl, A, B  : op select and operands, captured with Start
//   Busy              : iterative op in progress (pipeline stall)
//   Done              : one-cycle pulse, results updated
//   ALUResult/HiResult: low / high result (product, quotient/remainder)
//   Zero              : ALUResult == 0
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ALUResult,
    output logic [WIDTH-1:0] HiResult,
    output logic             Zero
);

    localparam int unsigned SHW = $clog2(WIDTH);

    alu_state_t       state;
    alu_state_t       state_next;
    logic             load_c;
    logic             wr_c;
    logic [WIDTH-1:0] lo_d;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] single_lo;
    logic [WIDTH-1:0] single_hi;
    logic [WIDTH-1:0] eng_lo;
    logic [WIDTH-1:0] eng_hi;
    logic             eng_last;
    logic [SHW-1:0]   sh;
    logic [SHW:0]     rsh;

    // Single-cycle datapath. A right shift by WIDTH yields 0, so a rotate by 0 returns A.
    always_comb begin
        sh        = B[SHW-1:0];
        rsh       = (SHW+1)'(WIDTH) - (SHW+1)'(sh);
        single_lo = '0;
        single_hi = '0;
        case (ALUControl)
            OP_AND:  single_lo = A & B;
            OP_OR:   single_lo = A | B;
            OP_ADD:  single_lo = A + B;
            OP_XOR:  single_lo = A ^ B;
            OP_SLL:  single_lo = A << sh;
            OP_SRL:  single_lo = A >> sh;
            OP_SUB:  single_lo = A - B;
            OP_SLT:  single_lo = WIDTH'($signed(A) < $signed(B));
            OP_ROTL: single_lo = (A << sh) | (A >> rsh);
            OP_ROTR: single_lo = (A >> sh) | (A << rsh);
            OP_NOR:  single_lo = ~(A | B);
            OP_ERR:  single_lo = '1;
            OP_DIVU: begin
                single_lo = '1;
                single_hi = A;
            end
            default: single_lo = '0;
        endcase
    end

    alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (Clk),
        .reset     (Reset),
        .load      (load_c),
        .step      (state == RUN),
        .op_mul    (ALUControl == OP_MUL),
        .a         (A),
        .b         (B),
        .result_lo (eng_lo),
        .result_hi (eng_hi),
        .last      (eng_last)
    );

    // Next state, engine load and result write select.
    always_comb begin
        state_next = state;
        load_c     = 1'b0;
        wr_c       = 1'b0;
        lo_d       = single_lo;
        hi_d       = single_hi;
        case (state)
            IDLE: begin
                if (Start) begin
                    if (is_iterative(ALUControl, B == '0)) begin
                        load_c     = 1'b1;
                        state_next = RUN;
                    end else begin
                        wr_c = 1'b1;
                    end
                end
            end
            RUN: begin
                if (eng_last) begin
                    wr_c       = 1'b1;
                    lo_d       = eng_lo;
                    hi_d       = eng_hi;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            ALUResult <= '0;
            HiResult  <= '0;
        end else begin
            state <= state_next;
            Busy  <= (state_next == RUN);
            Done  <= wr_c;
            if (wr_c) begin
                ALUResult <= lo_d;
                HiResult  <= hi_d;
            end
        end
    end

    assign Zero = (ALUResult == '0);

endmodule
